// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CSUM,
    FLUSH,
    DONE,
    ERROR
  } state_t;

  // True when the requested word count does not fit in a 2**addr_w word imem.
  function automatic logic over_capacity(input logic [31:0] count, input int unsigned addr_w);
    return count > (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader; master is the host/imem side, slave the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes LSB-first into 32-bit words; word holds its value between completions.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_en,
  output logic        last_lane,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [LANE_W-1:0] lane;
  logic [23:0]       sr;

  assign last_lane = (lane == LANE_W'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      lane       <= '0;
      sr         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_en) begin
        if (last_lane) begin
          word       <= {byte_in, sr};
          word_valid <= 1'b1;
          lane       <= '0;
        end else begin
          sr   <= {byte_in, sr[23:8]};
          lane <= lane + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header + LE words from a byte stream into imem, CPU held in reset until done.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus,
  output logic          cpu_reset,
  output logic          done,
  output logic          error
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W-1:0] hdr_count;
  logic             flush_wait;
  logic             accept;
  logic             wa_last;
  logic             wa_valid;
  logic [31:0]      wa_word;

  assign accept    = bus.in_valid && bus.in_ready;
  assign hdr_count = CNT_W'({bus.in_data, count[7:0]});

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic [7:0] csum_total;
  assign csum_total = csum + bus.in_data;
`endif

  word_assembler u_wa (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (bus.in_data),
    .byte_en    (accept && (state == DATA)),
    .last_lane  (wa_last),
    .word       (wa_word),
    .word_valid (wa_valid)
  );

  assign bus.imem_we    = wa_valid;
  assign bus.imem_wdata = wa_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HDR0;
      bus.in_ready  <= 1'b0;
      bus.imem_addr <= '0;
      count         <= '0;
      word_idx      <= '0;
      flush_wait    <= 1'b0;
      cpu_reset     <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (accept) csum <= csum_total;
`endif
      case (state)
        HDR0: begin
          bus.in_ready <= 1'b1;
          if (accept) begin
            count[7:0] <= bus.in_data;
            state      <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            count <= hdr_count;
            if (hdr_count == '0) begin
              state        <= FLUSH;
              bus.in_ready <= 1'b0;
            end else if (over_capacity(32'(hdr_count), ADDR_W)) begin
              state        <= ERROR;
              bus.in_ready <= 1'b0;
              error        <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept && wa_last) begin
            bus.imem_addr <= word_idx[ADDR_W-1:0];
            word_idx      <= word_idx + CNT_W'(1);
            if (word_idx == count - CNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CSUM;
`else
              state        <= FLUSH;
              bus.in_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            if (csum_total == 8'h00) begin
              state <= FLUSH;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        // FLUSH spans two cycles so release always lands two edges after the final byte,
        // the first of which may still carry the last write strobe.
        FLUSH: begin
          if (!flush_wait) begin
            flush_wait <= 1'b1;
          end else begin
            state     <= DONE;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; extra checksum cases when IMEM_LOADER_CHECKSUM_EN is set.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic cpu_reset;
  logic done;
  logic error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];
  logic [7:0]        frm[$];
  int                gap[$];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      log_addr.push_back(bus.imem_addr);
      log_data.push_back(bus.imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag, input int idx, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data);
    if (idx < log_addr.size()) begin
      check({tag, "_addr"}, 32'(log_addr[idx]), exp_addr);
      check({tag, "_data"}, log_data[idx], exp_data);
    end else begin
      check({tag, "_missing"}, log_addr.size(), idx + 1);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_cycles);
    int n;
    repeat (gap_cycles) @(negedge clk);
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Sends frm (with per-byte gaps) and, in the checksum build, a closing checksum byte.
  task automatic send_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = '0;
`endif
    foreach (frm[i]) begin
      send_byte(frm[i], (i < gap.size()) ? gap[i] : 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      s = s + frm[i];
`endif
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00 - s, 0);
`endif
  endtask

  task automatic expect_done(input string tag, input logic exp_we);
    @(negedge clk);
    check({tag, "_we_t0"}, 32'(bus.imem_we), 32'(exp_we));
    check({tag, "_done_t0"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, "_we_t1"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_done_t1"}, 32'(done), 32'd0);
    check({tag, "_cpurst_t1"}, 32'(cpu_reset), 32'd1);
    @(negedge clk);
    check({tag, "_done_t2"}, 32'(done), 32'd1);
    check({tag, "_cpurst_t2"}, 32'(cpu_reset), 32'd0);
    check({tag, "_ready_t2"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_error_t2"}, 32'(error), 32'd0);
  endtask

  function automatic logic [31:0] word_of(input int i);
    logic [7:0] v;
    v = 8'(i);
    return {8'hA5, v, ~v, 8'h3C};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [31:0] w;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_we", 32'(bus.imem_we), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_wdata", bus.imem_wdata, 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Two-word image, continuous stream.
    frm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h33, 8'h01, 8'h02, 8'h00};
    gap = {};
    send_frame();
    expect_done("two_word", !CSUM_EN);
    check("two_word_nwr", log_addr.size(), 32'd2);
    check_log("two_word_w0", 0, 32'd0, 32'h0000_0013);
    check_log("two_word_w1", 1, 32'd1, 32'h0002_0133);
    check("two_word_hold_addr", 32'(bus.imem_addr), 32'd1);
    check("two_word_hold_data", bus.imem_wdata, 32'h0002_0133);

    // Empty image.
    do_reset();
    frm = '{8'h00, 8'h00};
    send_frame();
    expect_done("empty", 1'b0);
    check("empty_nwr", log_addr.size(), 32'd0);

    // Oversized header: 257 words.
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    check("big_error", 32'(error), 32'd1);
    check("big_cpurst", 32'(cpu_reset), 32'd1);
    check("big_ready", 32'(bus.in_ready), 32'd0);
    bus.in_data  = 8'h55;
    bus.in_valid = 1'b1;
    repeat (6) @(negedge clk);
    bus.in_valid = 1'b0;
    check("big_error_hold", 32'(error), 32'd1);
    check("big_done", 32'(done), 32'd0);
    check("big_nwr", log_addr.size(), 32'd0);

    // One word with in_valid gaps inside it.
    do_reset();
    frm = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    gap = '{0, 0, 2, 1, 3, 2};
    send_frame();
    gap = {};
    expect_done("gaps", !CSUM_EN);
    check("gaps_nwr", log_addr.size(), 32'd1);
    check_log("gaps_w0", 0, 32'd0, 32'hDEAD_BEEF);

    // Reset part-way through the second word, then a fresh one-word image.
    do_reset();
    frm = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < HDR_BYTES + 6; i++) send_byte(frm[i], 0);
    do_reset();
    check("midrst_cpurst", 32'(cpu_reset), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_addr", 32'(bus.imem_addr), 32'd0);
    frm = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame();
    expect_done("midrst", !CSUM_EN);
    check("midrst_nwr", log_addr.size(), 32'd1);
    check_log("midrst_w0", 0, 32'd0, 32'hDDCC_BBAA);

    // Full-capacity image: 256 words fill addresses 0..255.
    do_reset();
    frm = '{8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      w = word_of(i);
      for (int k = 0; k < WORD_BYTES; k++) frm.push_back(w[8*k +: 8]);
    end
    send_frame();
    expect_done("max", !CSUM_EN);
    check("max_nwr", log_addr.size(), 32'd256);
    bad = 0;
    for (int i = 0; i < log_addr.size(); i++) begin
      if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== word_of(i)) bad++;
    end
    check("max_bad_words", bad, 32'd0);
    check_log("max_last", 255, 32'd255, word_of(255));
    check("max_hold_addr", 32'(bus.imem_addr), 32'd255);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    frm = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFE};
    foreach (frm[i]) send_byte(frm[i], 0);
    expect_done("csum_ok", 1'b0);
    check_log("csum_ok_w0", 0, 32'd0, 32'h0000_0001);

    do_reset();
    frm[6] = 8'hFF;
    foreach (frm[i]) send_byte(frm[i], 0);
    @(negedge clk);
    check("csum_bad_error", 32'(error), 32'd1);
    check("csum_bad_cpurst", 32'(cpu_reset), 32'd1);
    check("csum_bad_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("csum_bad_done", 32'(done), 32'd0);
    check("csum_bad_cpurst_hold", 32'(cpu_reset), 32'd1);
    check_log("csum_bad_w0", 0, 32'd0, 32'h0000_0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
